imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
- Sequences a byte-wide, combinational-read instruction memory and shares it between two word requesters: the CPU fetch port and a debug/loader read port.
- Performs four byte reads per word and assembles them big-endian: the byte at the lowest address goes in [31:24].
- Checks alignment and bounds, and returns one 32-bit word or an error per request.
- Sits between the fetch stage and the byte memory in place of the direct pc-to-memory connection.

Parameters:
- MEM_BYTES, 101: number of addressable bytes in the memory (valid byte addresses 0..MEM_BYTES-1).
- ADDR_W, 32: width of all address ports.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  when low, no new request is granted; an in-flight access still completes.
- cpu_req  in  1  CPU word request (level).
- cpu_addr  in  ADDR_W  CPU byte address of the word.
- cpu_rdy  out  1  one-cycle response pulse to the CPU.
- cpu_err  out  1  valid with cpu_rdy: misaligned or out-of-range request.
- cpu_inst  out  32  fetched word; valid with cpu_rdy.
- dbg_req  in  1  debug word request (level).
- dbg_addr  in  ADDR_W  debug byte address of the word.
- dbg_rdy  out  1  one-cycle response pulse to the debug port.
- dbg_err  out  1  valid with dbg_rdy.
- dbg_data  out  32  fetched word; valid with dbg_rdy.
- mem_addr  out  ADDR_W  byte address driven to the memory.
- mem_rd  out  1  memory read enable.
- mem_byte  in  8  memory read data, combinational from mem_addr in the same cycle.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All rdy, err and mem_rd outputs are 0; mem_addr is 0; cpu_inst and dbg_data are 0.
  - Round-robin pointer favours CPU.
  - Any in-flight access is discarded with no rdy pulse.
- States: IDLE, RD0, RD1, RD2, RD3, RESP.
- IDLE:
  - A grant happens when en=1 and at least one req is high.
  - If only one req is high, that requester is granted.
  - If both are high, the requester not granted last wins; CPU wins the first tie after reset.
  - On grant: latch the requester id and address, then update the round-robin pointer.
  - Error check on the latched address: err if addr[1:0]!=0, or if addr > MEM_BYTES-4.
  - If err: go to RESP with the error flag set; no memory cycles occur.
  - Otherwise: go to RD0.
- RDk (k=0..3):
  - mem_rd=1 and mem_addr=base+k.
  - At the clock edge, mem_byte is captured into byte lane k. Lane 0 is [31:24], lane 3 is [7:0].
  - RDk goes to RD(k+1); RD3 goes to RESP.
  - mem_rd=0 in every other state.
- RESP:
  - The granted port's rdy=1 for exactly one cycle, with the assembled word on its data output, or with err=1. On err the data output is left unchanged.
  - The other port's rdy stays 0.
  - Next state is IDLE.
- Latency:
  - Valid access: req sampled in IDLE at cycle 0 gives rdy in cycle 5.
  - Error: rdy in cycle 1.
  - Sustained throughput is one word per 6 cycles.
- Handshake:
  - A requester holds req and addr stable until its rdy.
  - The controller ignores addr changes after the grant, because the address was latched.
  - req still high in the cycle after rdy counts as a new request.
  - Dropping req before rdy does not abort the access; the rdy pulse is still issued.
- Data outputs hold their last value between responses.
- Address arithmetic: base+k is computed at ADDR_W bits; no wrap is possible because out-of-range addresses are rejected first.
- en=0 while in RDx or RESP has no effect until the controller returns to IDLE.

Decomposition:
- Shared package imem_pkg holds:
  - the state enum (IDLE, RD0..RD3, RESP);
  - the requester id constants REQ_CPU=0 and REQ_DBG=1;
  - BYTE_W=8 and WORD_BYTES=4.
- One sub-module, rr_arb2: a two-requester round-robin arbiter.
  - Inputs: req[1:0] and an advance strobe.
  - Output: a one-hot grant.
  - Holds the last-granted pointer and resets to favour CPU.

Test Plan:
- Preload bytes 0..3 = 8'h20,8'h08,8'h00,8'h05. cpu_req=1, cpu_addr=0 at cycle 0. Required: mem_addr steps 0,1,2,3 in cycles 1-4; cpu_rdy=1 in cycle 5 only; cpu_inst=32'h20080005; cpu_err=0; dbg_rdy stays 0.
- cpu_addr=2 (misaligned): cpu_rdy and cpu_err=1 in cycle 1; mem_rd never asserts. Repeat with cpu_addr=100, where 100 > 97: same error response.
- cpu_addr=96 with bytes 96..99 = 8'hAA,8'hBB,8'hCC,8'hDD: cpu_inst=32'hAABBCCDD and no error. This is the highest valid address.
- cpu_req and dbg_req held high from reset, with addresses 0 and 4: responses come in the order CPU, DBG, CPU, DBG; each rdy is 6 cycles after the previous one; each port gets the correct data.
- Assert reset during RD2 of a CPU access: no cpu_rdy pulse; all outputs 0 the cycle after reset; with req still high, a fresh access starts in the first cycle after reset deasserts.
- en=0 with cpu_req=1: no mem_rd for 10 cycles. Raise en: access starts, and rdy arrives 5 cycles after the first IDLE cycle with en=1.

Source files
------------

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory fetch controller:
//   - state_t      : fetch FSM states (IDLE, RD0..RD3, RESP)
//   - REQ_CPU/DBG  : requester ids, also used as bit positions in req/grant
//   - BYTE_W       : memory data width
//   - WORD_BYTES   : bytes per fetched word
// ---------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    RESP = 3'd5
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

endpackage : imem_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request vector, bit REQ_CPU / bit REQ_DBG
//   adv        : grant is being taken this cycle; update the pointer
//   gnt[1:0]   : one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module rr_arb2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // Id of the requester granted most recently. Resetting to DBG makes the
  // CPU win the first tie.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) begin
      // Tie: the requester not served last wins.
      gnt = (last_q == REQ_CPU) ? 2'b10 : 2'b01;
    end
    if (adv && (gnt != 2'b00)) begin
      last_d = gnt[REQ_DBG];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Shares a byte-wide, combinational-read instruction memory between the CPU
// fetch port and a debug/loader port. Each granted request is checked for
// alignment and range, then read as four bytes assembled big-endian (lowest
// address in [31:24]) and answered with a one-cycle rdy pulse.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   en                            : allow new grants (in-flight access completes)
//   cpu_req/cpu_addr              : CPU word request, held until cpu_rdy
//   cpu_rdy/cpu_err/cpu_inst      : CPU response
//   dbg_req/dbg_addr              : debug word request, held until dbg_rdy
//   dbg_rdy/dbg_err/dbg_data      : debug response
//   mem_addr/mem_rd/mem_byte      : byte memory interface
// ---------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 101,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rdy,
  output logic              cpu_err,
  output logic [31:0]       cpu_inst,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_rdy,
  output logic              dbg_err,
  output logic [31:0]       dbg_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [BYTE_W-1:0] mem_byte
);

  // Highest word base address whose four bytes all exist.
  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_t            state_q, state_d;
  logic              id_q, id_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       word_q, word_d;      // lanes 0..2; lane 3 comes straight from mem_byte
  logic [31:0]       cpu_inst_q, cpu_inst_d;
  logic [31:0]       dbg_data_q, dbg_data_d;

  logic [1:0]        gnt;
  logic              grant_vld;
  logic [ADDR_W-1:0] grant_addr;
  logic [31:0]       word_full;

  assign grant_vld  = (state_q == IDLE) && en && (gnt != 2'b00);
  assign grant_addr = gnt[REQ_DBG] ? dbg_addr : cpu_addr;
  assign word_full  = {word_q, mem_byte};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({dbg_req, cpu_req}),
    .adv   (grant_vld),
    .gnt   (gnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      id_q       <= REQ_CPU;
      err_q      <= 1'b0;
      cpu_inst_q <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      err_q      <= err_d;
      cpu_inst_q <= cpu_inst_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Latched address and partial word carry no meaning outside an access.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    word_q <= word_d;
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    err_d      = err_q;
    addr_d     = addr_q;
    word_d     = word_q;
    cpu_inst_d = cpu_inst_q;
    dbg_data_d = dbg_data_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          id_d    = gnt[REQ_DBG];
          addr_d  = grant_addr;
          err_d   = (grant_addr[1:0] != 2'b00) || (grant_addr > MAX_BASE);
          state_d = err_d ? RESP : RD0;
        end
      end
      RD0: begin
        word_d[23:16] = mem_byte;
        state_d       = RD1;
      end
      RD1: begin
        word_d[15:8] = mem_byte;
        state_d      = RD2;
      end
      RD2: begin
        word_d[7:0] = mem_byte;
        state_d     = RD3;
      end
      RD3: begin
        // Final lane goes directly to the port register so data is valid in RESP.
        if (id_q == REQ_CPU) cpu_inst_d = word_full;
        else                 dbg_data_d = word_full;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    unique case (state_q)
      RD0: begin mem_rd = 1'b1; mem_addr = addr_q;                 end
      RD1: begin mem_rd = 1'b1; mem_addr = addr_q + ADDR_W'(1);    end
      RD2: begin mem_rd = 1'b1; mem_addr = addr_q + ADDR_W'(2);    end
      RD3: begin mem_rd = 1'b1; mem_addr = addr_q + ADDR_W'(3);    end
      default: ;
    endcase
    cpu_rdy  = (state_q == RESP) && (id_q == REQ_CPU);
    dbg_rdy  = (state_q == RESP) && (id_q == REQ_DBG);
    cpu_err  = cpu_rdy && err_q;
    dbg_err  = dbg_rdy && err_q;
    cpu_inst = cpu_inst_q;
    dbg_data = dbg_data_q;
  end

endmodule : imem_fetch_ctrl
